sirv_plic_claim_master: RTL and testbench

Hardware claim/complete engine that sits on the initiator side of the PLIC's ICB slave port, on behalf of hart context 0. When the PLIC interrupt output is asserted, it issues an ICB read to the claim/complete register. It then hands the claimed ID to a local consumer over a valid/ready handshake, waits for the consumer's done pulse, and writes the ID back to complete. This offloads claim/complete traffic from the core for low-latency fixed-function interrupt handlers.

---
 rtl/sirv_plic_claim_master.sv | 137 +++++++++++++
 tb/tb_sirv_plic_claim_master.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_plic_claim_master.sv
// Hardware claim/complete engine for PLIC hart context 0: claims over ICB,
// hands the ID to a local consumer, then writes the ID back to complete.
module sirv_plic_claim_master #(
  parameter logic [31:0] PLIC_BASE = 32'h0C00_0000,
  parameter logic [31:0] CLAIM_OFS = 32'h0020_0004,
  parameter int          ID_W      = 10,
  parameter int          HOLDOFF   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            plic_irq_i,
  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic [31:0]     o_icb_cmd_addr,
  output logic            o_icb_cmd_read,
  output logic [31:0]     o_icb_cmd_wdata,
  output logic [3:0]      o_icb_cmd_wmask,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic [31:0]     o_icb_rsp_rdata,
  input  logic            o_icb_rsp_err,
  output logic            irq_vld,
  input  logic            irq_rdy,
  output logic [ID_W-1:0] irq_id,
  input  logic            done_i,
  input  logic            err_clr,
  output logic            busy,
  output logic            err,
  output logic [7:0]      spur_cnt
);

  localparam int HO_W = (HOLDOFF < 8) ? 3 : $clog2(HOLDOFF + 1);
  // The response cycle itself is the first ignored cycle, so the counter
  // covers the remaining HOLDOFF-1 idle cycles.
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLM_CMD,
    CLM_RSP,
    DELIVER,
    WAIT_DONE,
    CMP_CMD,
    CMP_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [HO_W-1:0]   hold_q, hold_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        spur_q, spur_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              unused_rdata_hi;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign unused_rdata_hi = ^o_icb_rsp_rdata[31:ID_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      id_q    <= '0;
      spur_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      id_q    <= id_d;
      spur_q  <= spur_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    id_d    = id_q;
    spur_d  = spur_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HO_W'(1);
        end else if (en && plic_irq_i) begin
          state_d = CLM_CMD;
        end
      end
      CLM_CMD: if (o_icb_cmd_ready) state_d = CLM_RSP;
      CLM_RSP: begin
        if (o_icb_rsp_valid) begin
          if (o_icb_rsp_err) begin
            err_set = 1'b1;
            state_d = IDLE;
            hold_d  = HO_LOAD;
          end else if (o_icb_rsp_rdata[ID_W-1:0] == '0) begin
            spur_d  = sat_inc(spur_q);
            state_d = IDLE;
            hold_d  = HO_LOAD;
          end else begin
            id_d    = o_icb_rsp_rdata[ID_W-1:0];
            state_d = DELIVER;
          end
        end
      end
      DELIVER:   if (irq_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (done_i) state_d = CMP_CMD;
      CMP_CMD:   if (o_icb_cmd_ready) state_d = CMP_RSP;
      CMP_RSP: begin
        if (o_icb_rsp_valid) begin
          err_set = o_icb_rsp_err;
          state_d = IDLE;
          hold_d  = HO_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new error outranks a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  assign o_icb_cmd_valid = (state_q == CLM_CMD) || (state_q == CMP_CMD);
  assign o_icb_cmd_read  = (state_q != CMP_CMD);
  assign o_icb_cmd_addr  = PLIC_BASE + CLAIM_OFS;
  assign o_icb_cmd_wdata = {{(32-ID_W){1'b0}}, id_q};
  assign o_icb_cmd_wmask = 4'hF;
  assign o_icb_rsp_ready = (state_q == CLM_RSP) || (state_q == CMP_RSP);
  assign irq_vld         = (state_q == DELIVER);
  assign irq_id          = id_q;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;
  assign spur_cnt        = spur_q;

endmodule

// File: tb/tb_sirv_plic_claim_master.sv
// Bench for sirv_plic_claim_master: ICB responder and consumer serviced each
// cycle, with a transaction-level expectation model.
module tb_sirv_plic_claim_master;
  localparam int          HOLDOFF = 4;
  localparam logic [31:0] ADDR    = 32'h0C20_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        plic_irq = 1'b0;
  logic        cmd_valid, cmd_read;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid = 1'b0, rsp_err = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata = 32'h0;
  logic        irq_vld;
  logic        irq_rdy = 1'b0;
  logic [9:0]  irq_id;
  logic        cons_done = 1'b0, stray_done = 1'b0, done_i;
  logic        tb_err_clr = 1'b0, clr_on_rsp = 1'b0, err_clr;
  logic        busy, err;
  logic [7:0]  spur;

  assign done_i  = cons_done | stray_done;
  assign err_clr = tb_err_clr | (clr_on_rsp & rsp_valid);

  always #5 clk = ~clk;

  sirv_plic_claim_master dut (
    .clk(clk), .rst_n(rst_n), .en(en), .plic_irq_i(plic_irq),
    .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready),
    .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_read(cmd_read),
    .o_icb_cmd_wdata(cmd_wdata), .o_icb_cmd_wmask(cmd_wmask),
    .o_icb_rsp_valid(rsp_valid), .o_icb_rsp_ready(rsp_ready),
    .o_icb_rsp_rdata(rsp_rdata), .o_icb_rsp_err(rsp_err),
    .irq_vld(irq_vld), .irq_rdy(irq_rdy), .irq_id(irq_id),
    .done_i(done_i), .err_clr(err_clr), .busy(busy), .err(err),
    .spur_cnt(spur)
  );

  typedef struct {
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          first;
    int          hold;
  } cmd_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int total = 0, bad = 0, cyc = 0;
  cmd_t cmd_log[$];
  rsp_t rsp_q[$];
  int   rsp_cyc[$];
  logic [9:0] dlv_id[$];
  int   dlv_cyc[$], dlv_hold[$];
  int   cmd_wait = 0, rsp_wait = 0, rdy_wait = 0, done_dly = 0;
  bit   done_auto = 1'b1;
  int   unstable = 0, vld_unstable = 0;

  bit   c_track = 0, c_hs = 0, r_pend = 0;
  int   c_cnt = 0, r_cnt = 0;
  cmd_t c_cur;
  bit   k_track = 0, k_hs = 0, k_wait = 0;
  int   k_rc = 0, k_dc = 0, k_first = 0, k_hold = 0;
  logic [9:0] k_id;

  // One clock of ICB slave and consumer behaviour, evaluated mid-cycle.
  task automatic step();
    rsp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      cmd_ready = 0; rsp_valid = 0; rsp_err = 0; c_track = 0; c_hs = 0; r_pend = 0;
      irq_rdy = 0; cons_done = 0; k_track = 0; k_hs = 0; k_wait = 0;
      return;
    end
    rsp_valid = 0;
    rsp_err   = 0;
    if (c_hs) begin
      c_hs = 0; cmd_ready = 0; r_pend = 1; r_cnt = rsp_wait;
    end
    if (r_pend && rsp_ready) begin
      if (r_cnt > 0) r_cnt--;
      else begin
        r_pend = 0; rsp_valid = 1;
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front(); rsp_rdata = e.rdata; rsp_err = e.err;
        end else begin
          rsp_rdata = 32'h0; rsp_err = 1'b0;
        end
        rsp_cyc.push_back(cyc);
      end
    end
    if (cmd_valid) begin
      if (!c_track) begin
        c_track = 1; c_cur.read = cmd_read; c_cur.addr = cmd_addr;
        c_cur.wdata = cmd_wdata; c_cur.first = cyc; c_cur.hold = 0; c_cnt = cmd_wait;
      end else if (cmd_read !== c_cur.read || cmd_addr !== c_cur.addr || cmd_wdata !== c_cur.wdata) begin
        unstable++;
      end
      c_cur.hold++;
      if (c_cnt > 0) begin c_cnt--; cmd_ready = 0; end
      else begin cmd_ready = 1; c_hs = 1; c_track = 0; cmd_log.push_back(c_cur); end
    end else cmd_ready = 0;

    cons_done = 0;
    if (k_hs) begin k_hs = 0; irq_rdy = 0; k_wait = done_auto; k_dc = done_dly; end
    if (k_wait) begin
      if (k_dc > 0) k_dc--;
      else begin cons_done = 1; k_wait = 0; end
    end
    if (irq_vld) begin
      if (!k_track) begin
        k_track = 1; k_id = irq_id; k_first = cyc; k_hold = 0; k_rc = rdy_wait;
      end else if (irq_id !== k_id) vld_unstable++;
      k_hold++;
      if (k_rc > 0) begin k_rc--; irq_rdy = 0; end
      else begin
        irq_rdy = 1; k_hs = 1; k_track = 0;
        dlv_id.push_back(k_id); dlv_cyc.push_back(k_first); dlv_hold.push_back(k_hold);
      end
    end else irq_rdy = 0;
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  task automatic clear_logs();
    cmd_log.delete(); rsp_cyc.delete(); dlv_id.delete(); dlv_cyc.delete(); dlv_hold.delete();
    unstable = 0; vld_unstable = 0;
  endtask

  function automatic int n_reads();
    int n = 0;
    foreach (cmd_log[i]) if (cmd_log[i].read) n++;
    return n;
  endfunction

  function automatic cmd_t cmd_at(input int i);
    cmd_t z;
    z.read = 1'bx; z.addr = 32'hx; z.wdata = 32'hx; z.first = -1; z.hold = -1;
    return (i < cmd_log.size()) ? cmd_log[i] : z;
  endfunction

  task automatic wait_busy(input logic lvl, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy === lvl) begin ok = 1; break; end
    end
  endtask

  task automatic wait_reads(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_reads() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic launch(output bit ok);
    bit a, b;
    plic_irq = 1; wait_busy(1'b1, 40, a);
    plic_irq = 0; wait_busy(1'b0, 400, b);
    ok = a & b;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if ({cmd_valid, cmd_read, rsp_ready, irq_vld, busy, err} !== 6'b010000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=010000", {cmd_valid, cmd_read, rsp_ready, irq_vld, busy, err}); end
    total++; if ({irq_id, spur, cmd_wdata} !== 50'h0) begin
      bad++; $display("FAIL reset_data got id=%0d spur=%0d wdata=%h exp=0", irq_id, spur, cmd_wdata); end
    rst_n = 1'b1; en = 1'b1;
    step();
    total++; if ({cmd_valid, cmd_read, rsp_ready, irq_vld, busy} !== 5'b01000) begin
      bad++; $display("FAIL post_reset_ctrl got=%b exp=01000", {cmd_valid, cmd_read, rsp_ready, irq_vld, busy}); end
    total++; if (cmd_addr !== ADDR || cmd_wmask !== 4'hF) begin
      bad++; $display("FAIL const_addr_mask got=%h/%h exp=%h/f", cmd_addr, cmd_wmask, ADDR); end
  endtask

  task automatic test_basic();
    bit a, b;
    int t0;
    cmd_t c0, c1;
    clear_logs();
    push_rsp(32'd5, 1'b0); push_rsp(32'd0, 1'b0);
    plic_irq = 1; t0 = cyc;
    wait_busy(1'b1, 20, a); plic_irq = 0;
    wait_busy(1'b0, 200, b);
    total++; if (!(a && b)) begin bad++; $display("FAIL basic_timeout got=%0d%0d exp=11", a, b); end
    c0 = cmd_at(0); c1 = cmd_at(1);
    total++; if (cmd_log.size() != 2) begin bad++; $display("FAIL basic_ncmd got=%0d exp=2", cmd_log.size()); end
    total++; if (c0.read !== 1'b1 || c0.addr !== ADDR || c0.first != t0 + 1) begin
      bad++; $display("FAIL basic_claim got read=%b addr=%h cyc=%0d exp 1 %h %0d", c0.read, c0.addr, c0.first, ADDR, t0 + 1); end
    total++; if (dlv_id.size() != 1 || dlv_id[0] !== 10'd5 || dlv_cyc[0] != t0 + 3) begin
      bad++; $display("FAIL basic_deliver got n=%0d exp id 5 at %0d", dlv_id.size(), t0 + 3); end
    total++; if (c1.read !== 1'b0 || c1.addr !== ADDR || c1.wdata !== 32'd5) begin
      bad++; $display("FAIL basic_complete got read=%b addr=%h wdata=%h exp 0 %h 5", c1.read, c1.addr, c1.wdata, ADDR); end
    total++; if (rsp_cyc.size() != 2 || cyc != rsp_cyc[1] + 1 || irq_id !== 10'd5) begin
      bad++; $display("FAIL basic_idle got cyc=%0d id=%0d exp busy low right after complete rsp, id 5", cyc, irq_id); end
  endtask

  task automatic test_backpressure();
    bit ok;
    cmd_t c0, c1;
    clear_logs();
    cmd_wait = 3; rdy_wait = 2;
    push_rsp(32'hA5A5_5523, 1'b0); push_rsp(32'd0, 1'b0);
    launch(ok);
    cmd_wait = 0; rdy_wait = 0;
    c0 = cmd_at(0); c1 = cmd_at(1);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
    total++; if (unstable != 0 || vld_unstable != 0) begin
      bad++; $display("FAIL bp_stable got cmd=%0d vld=%0d exp=0 0", unstable, vld_unstable); end
    total++; if (n_reads() != 1 || c0.hold != 4) begin
      bad++; $display("FAIL bp_claim got reads=%0d hold=%0d exp 1 4", n_reads(), c0.hold); end
    total++; if (dlv_hold.size() != 1 || dlv_hold[0] != 3 || dlv_id[0] !== 10'h123) begin
      bad++; $display("FAIL bp_deliver got n=%0d exp id 123 held 3", dlv_hold.size()); end
    total++; if (c1.read !== 1'b0 || c1.wdata !== 32'h123) begin
      bad++; $display("FAIL bp_complete got read=%b wdata=%h exp 0 123", c1.read, c1.wdata); end
  endtask

  task automatic test_spurious();
    bit a, b;
    logic [7:0] s0;
    cmd_t c1, c2;
    clear_logs();
    s0 = spur;
    push_rsp(32'hFFFF_FC00, 1'b0); push_rsp(32'd7, 1'b0); push_rsp(32'd0, 1'b0);
    plic_irq = 1;
    wait_reads(2, 300, a); plic_irq = 0;
    wait_busy(1'b0, 300, b);
    c1 = cmd_at(1); c2 = cmd_at(2);
    total++; if (!(a && b)) begin bad++; $display("FAIL spur_timeout got=%0d%0d exp=11", a, b); end
    total++; if (spur !== s0 + 8'd1) begin bad++; $display("FAIL spur_cnt got=%0d exp=%0d", spur, s0 + 8'd1); end
    total++; if (dlv_id.size() != 1 || dlv_id[0] !== 10'd7) begin
      bad++; $display("FAIL spur_nodeliver got n=%0d exp only id 7", dlv_id.size()); end
    total++; if (cmd_log.size() != 3 || c1.read !== 1'b1 || rsp_cyc.size() < 1 || c1.first != rsp_cyc[0] + HOLDOFF + 1) begin
      bad++; $display("FAIL spur_next_claim got n=%0d cyc=%0d exp 3 cmds, claim %0d after rsp", cmd_log.size(), c1.first, HOLDOFF + 1); end
    total++; if (c2.read !== 1'b0 || c2.wdata !== 32'd7) begin
      bad++; $display("FAIL spur_complete got read=%b wdata=%h exp 0 7", c2.read, c2.wdata); end
  endtask

  task automatic test_errors();
    bit ok;
    clear_logs();
    push_rsp(32'd9, 1'b1);
    launch(ok);
    total++; if (!ok || err !== 1'b1 || dlv_id.size() != 0 || cmd_log.size() != 1) begin
      bad++; $display("FAIL err_claim got ok=%0d err=%b dlv=%0d ncmd=%0d exp 1 1 0 1", ok, err, dlv_id.size(), cmd_log.size()); end
    tb_err_clr = 1; step(); tb_err_clr = 0; step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    clr_on_rsp = 1;
    push_rsp(32'd9, 1'b1);
    launch(ok);
    clr_on_rsp = 0;
    total++; if (!ok || err !== 1'b1) begin bad++; $display("FAIL err_set_wins got ok=%0d err=%b exp 1 1", ok, err); end
    tb_err_clr = 1; step(); tb_err_clr = 0;
    clear_logs();
    push_rsp(32'd3, 1'b0); push_rsp(32'd0, 1'b1);
    launch(ok);
    total++; if (!ok || err !== 1'b1 || dlv_id.size() != 1 || cmd_log.size() != 2) begin
      bad++; $display("FAIL err_complete got ok=%0d err=%b dlv=%0d ncmd=%0d exp 1 1 1 2", ok, err, dlv_id.size(), cmd_log.size()); end
  endtask

  task automatic test_holdoff_enable();
    bit a, b;
    int busy_cnt = 0;
    cmd_t c2;
    clear_logs();
    push_rsp(32'd4, 1'b0); push_rsp(32'd0, 1'b0); push_rsp(32'd6, 1'b0); push_rsp(32'd0, 1'b0);
    plic_irq = 1;
    wait_reads(2, 400, a); plic_irq = 0;
    wait_busy(1'b0, 300, b);
    c2 = cmd_at(2);
    total++; if (!(a && b) || cmd_log.size() != 4 || rsp_cyc.size() < 2 || c2.first != rsp_cyc[1] + HOLDOFF + 1) begin
      bad++; $display("FAIL holdoff_gap got n=%0d cyc=%0d exp second claim %0d cycles after complete rsp", cmd_log.size(), c2.first, HOLDOFF + 1); end
    en = 0; plic_irq = 1;
    for (int i = 0; i < 20; i++) begin step(); if (busy) busy_cnt++; end
    plic_irq = 0; en = 1;
    total++; if (cmd_log.size() != 4 || busy_cnt != 0) begin
      bad++; $display("FAIL enable_block got ncmd=%0d busy_cycles=%0d exp 4 0", cmd_log.size(), busy_cnt); end
  endtask

  task automatic test_reset_mid();
    bit a;
    int busy_cnt = 0;
    clear_logs();
    done_auto = 0;
    push_rsp(32'd8, 1'b0);
    plic_irq = 1; wait_busy(1'b1, 40, a); plic_irq = 0;
    for (int i = 0; i < 50 && dlv_id.size() == 0; i++) step();
    step();
    total++; if (!a || busy !== 1'b1 || irq_vld !== 1'b0 || irq_id !== 10'd8) begin
      bad++; $display("FAIL mid_wait_done got busy=%b vld=%b id=%0d exp 1 0 8", busy, irq_vld, irq_id); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({cmd_valid, cmd_read, rsp_ready, irq_vld, busy, err} !== 6'b010000 || {irq_id, spur, cmd_wdata} !== 50'h0) begin
      bad++; $display("FAIL mid_reset got ctrl=%b id=%0d spur=%0d wdata=%h exp 010000 0 0 0",
        {cmd_valid, cmd_read, rsp_ready, irq_vld, busy, err}, irq_id, spur, cmd_wdata); end
    step(); step();
    rst_n = 1'b1; done_auto = 1;
    step();
    clear_logs();
    stray_done = 1; step(); stray_done = 0;
    for (int i = 0; i < 12; i++) begin step(); if (busy) busy_cnt++; end
    total++; if (cmd_log.size() != 0 || busy_cnt != 0) begin
      bad++; $display("FAIL stray_done got ncmd=%0d busy_cycles=%0d exp 0 0", cmd_log.size(), busy_cnt); end
  endtask

  task automatic test_random();
    cmd_t exp_cmd[$];
    cmd_t x, g;
    logic [9:0] exp_dlv[$];
    logic [7:0] exp_spur;
    logic exp_err = 1'b0;
    logic [31:0] r;
    logic ce, we;
    bit ok;
    int to = 0;
    tb_err_clr = 1; step(); tb_err_clr = 0;
    clear_logs();
    exp_spur = spur;
    for (int it = 0; it < 24; it++) begin
      cmd_wait = $urandom_range(2); rsp_wait = $urandom_range(2);
      rdy_wait = $urandom_range(2); done_dly = $urandom_range(3);
      r = $urandom;
      if ($urandom_range(3) == 0) r[9:0] = 10'd0;
      else if (r[9:0] == 10'd0) r[0] = 1'b1;
      ce = ($urandom_range(7) == 0);
      we = ($urandom_range(7) == 0);
      push_rsp(r, ce);
      x.read = 1'b1; x.addr = ADDR; x.wdata = 32'h0; x.first = 0; x.hold = 0;
      exp_cmd.push_back(x);
      if (ce) exp_err = 1'b1;
      else if (r[9:0] == 10'd0) begin
        if (exp_spur != 8'hFF) exp_spur++;
      end else begin
        exp_dlv.push_back(r[9:0]);
        x.read = 1'b0; x.wdata = {22'h0, r[9:0]};
        exp_cmd.push_back(x);
        push_rsp($urandom, we);
        if (we) exp_err = 1'b1;
      end
      launch(ok);
      if (!ok) to++;
    end
    cmd_wait = 0; rsp_wait = 0; rdy_wait = 0; done_dly = 0;
    total++; if (to != 0 || rsp_q.size() != 0) begin
      bad++; $display("FAIL rand_progress got timeouts=%0d leftover_rsp=%0d exp 0 0", to, rsp_q.size()); end
    total++; if (cmd_log.size() != exp_cmd.size()) begin
      bad++; $display("FAIL rand_ncmd got=%0d exp=%0d", cmd_log.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      g = cmd_at(i);
      total++;
      if (g.read !== exp_cmd[i].read || g.addr !== ADDR || (!exp_cmd[i].read && g.wdata !== exp_cmd[i].wdata)) begin
        bad++; $display("FAIL rand_cmd%0d got read=%b addr=%h wdata=%h exp read=%b wdata=%h",
          i, g.read, g.addr, g.wdata, exp_cmd[i].read, exp_cmd[i].wdata); end
    end
    total++; if (dlv_id != exp_dlv) begin
      bad++; $display("FAIL rand_deliver got n=%0d exp n=%0d (ids differ)", dlv_id.size(), exp_dlv.size()); end
    total++; if (spur !== exp_spur || err !== exp_err) begin
      bad++; $display("FAIL rand_status got spur=%0d err=%b exp spur=%0d err=%b", spur, err, exp_spur, exp_err); end
    total++; if (unstable != 0 || vld_unstable != 0) begin
      bad++; $display("FAIL rand_stable got cmd=%0d vld=%0d exp 0 0", unstable, vld_unstable); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious();
    test_errors();
    test_holdoff_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
